// File: rtl/srm_mem_pkg.sv
// Shared types and default geometry for the single-port memory arbiter.
// Holds the FSM state encoding, the grant encoding and the default widths.
package srm_mem_pkg;

    localparam int ADDR_W_DEF     = 22;
    localparam int DATA_W_DEF     = 32;
    localparam int LINE_WORDS_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IFILL = 2'd1,
        DACC  = 2'd2
    } arb_state_e;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between icache line refills and core data accesses.
// Round-robin on ties, one IDLE turnaround cycle between grants.
module mem_port_arbiter
    import srm_mem_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int LINE_WORDS = LINE_WORDS_DEF
) (
    input  logic              clk,
    input  logic              Res,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_valid,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rdy
);

    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int LINE_W = ADDR_W - OFF_W;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

    arb_state_e        state_q;
    grant_e            last_grant_q;
    grant_e            grant_d;
    logic [OFF_W-1:0]  beat_cnt_q;
    logic [LINE_W-1:0] line_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;

    always_comb begin
        grant_d = GNT_I;
        if (i_req && d_req) begin
            grant_d = (last_grant_q == GNT_I) ? GNT_D : GNT_I;
        end else if (d_req) begin
            grant_d = GNT_D;
        end
    end

    // last_grant only moves on a tie, so alternation is between contended grants.
    always_ff @(posedge clk) begin
        if (Res) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_I;
            beat_cnt_q   <= '0;
            line_q       <= '0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_req || d_req) begin
                        if (i_req && d_req) begin
                            last_grant_q <= grant_d;
                        end
                        if (grant_d == GNT_I) begin
                            state_q <= IFILL;
                            line_q  <= LINE_W'(i_addr >> OFF_W);
                        end else begin
                            state_q <= DACC;
                            addr_q  <= d_addr;
                            we_q    <= d_we;
                            wdata_q <= d_wdata;
                        end
                    end
                end
                IFILL: begin
                    if (mem_rdy) begin
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                        if (beat_cnt_q == LAST_BEAT) begin
                            state_q <= IDLE;
                        end
                    end
                end
                DACC: begin
                    if (mem_rdy) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        i_valid   = 1'b0;
        i_rdata   = '0;
        i_done    = 1'b0;
        d_ack     = 1'b0;
        d_rdata   = '0;
        case (state_q)
            IFILL: begin
                mem_req  = 1'b1;
                mem_addr = {line_q, beat_cnt_q};
                if (mem_rdy) begin
                    i_valid = 1'b1;
                    i_rdata = mem_rdata;
                    i_done  = (beat_cnt_q == LAST_BEAT);
                end
            end
            DACC: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                if (mem_rdy) begin
                    d_ack   = 1'b1;
                    d_rdata = mem_rdata;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table plus directed corner sequences.
// Expected bus beats are queued at stimulus time and popped as the DUT completes them.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int AW = 22;
    localparam int DW = 32;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          Res;
    logic          i_req, i_valid, i_done;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          d_req, d_we, d_ack;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          mem_req, mem_we, mem_rdy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(LW)) dut (
        .clk(clk), .Res(Res),
        .i_req(i_req), .i_addr(i_addr), .i_valid(i_valid), .i_rdata(i_rdata), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_rdy(mem_rdy)
    );

    // Memory model: data is a fixed pattern of the address unless forced.
    logic          rd_force_en;
    logic [DW-1:0] rd_force_val;

    function automatic logic [DW-1:0] mem_model(input logic [AW-1:0] a);
        return 32'h5A00_0000 | {10'd0, a};
    endfunction

    always_comb mem_rdata = rd_force_en ? rd_force_val : mem_model(mem_addr);

    typedef struct {
        bit            is_d;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        bit            check_rdata;
        bit            last;
    } beat_t;

    typedef struct {
        bit            is_d;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        bit            force_rd;
        logic [DW-1:0] fval;
        int            exp_mreq;
    } vec_t;

    beat_t exp_q[$];
    int    compared   = 0;
    int    mismatched = 0;
    int    beats_seen = 0;
    int    done_cnt   = 0;
    int    ack_cnt    = 0;
    int    mreq_cycles = 0;
    bit    prev_end   = 1'b0;
    bit    mon_en     = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        beat_t e;
        if (mon_en) begin
            if (mem_req) mreq_cycles++;
            if (prev_end) check("turnaround_idle", mem_req, 0);
            prev_end = 1'b0;
            if (mem_req && mem_rdy) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_beat: got beat at addr 0x%0h, expected none", mem_addr);
                end else begin
                    e = exp_q.pop_front();
                    check("mem_we", mem_we, e.we);
                    check("mem_addr", mem_addr, e.addr);
                    check("mem_wdata", mem_wdata, e.wdata);
                    if (e.is_d) begin
                        check("d_ack", d_ack, 1);
                        check("i_valid_on_d", i_valid, 0);
                        if (e.check_rdata) check("d_rdata", d_rdata, e.rdata);
                    end else begin
                        check("i_valid", i_valid, 1);
                        check("i_rdata", i_rdata, e.rdata);
                        check("i_done", i_done, e.last);
                        check("d_ack_on_i", d_ack, 0);
                    end
                    $display("beat %0d: %s we=%0b addr=0x%06h", beats_seen, e.is_d ? "D" : "I", mem_we, mem_addr);
                end
                beats_seen++;
                if (i_done) done_cnt++;
                if (d_ack) ack_cnt++;
                prev_end = d_ack | i_done;
            end else begin
                check("no_strobe", {i_valid, i_done, d_ack}, 0);
                if (mem_req) begin
                    if (exp_q.size() > 0) check("stall_addr_hold", mem_addr, exp_q[0].addr);
                end else begin
                    check("idle_bus", {mem_we, mem_addr, mem_wdata}, 0);
                    check("idle_rdata", {i_rdata, d_rdata}, 0);
                end
            end
        end
    end

    task automatic push_fill(input logic [AW-1:0] a);
        logic [AW-1:0] base;
        beat_t e;
        base = a & ~AW'(LW - 1);
        for (int b = 0; b < LW; b++) begin
            e.is_d = 1'b0; e.we = 1'b0; e.addr = base + AW'(b); e.wdata = '0;
            e.rdata = mem_model(base + AW'(b)); e.check_rdata = 1'b1; e.last = (b == LW - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic push_d(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input logic [DW-1:0] rd);
        beat_t e;
        e.is_d = 1'b1; e.we = we; e.addr = a; e.wdata = wd; e.rdata = rd;
        e.check_rdata = !we; e.last = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input int d0, input int a0, input bit want_i, input bit want_d,
                             input string name);
        bit got_i, got_d;
        got_i = !want_i;
        got_d = !want_d;
        for (int c = 0; c < 100; c++) begin
            if (got_i && got_d) break;
            @(posedge clk); #1;
            if (!got_i && done_cnt != d0) begin got_i = 1'b1; i_req = 1'b0; end
            if (!got_d && ack_cnt != a0) begin got_d = 1'b1; d_req = 1'b0; end
        end
        if (!(got_i && got_d)) begin
            compared++;
            mismatched++;
            $display("FAIL %s_timeout: got i_done=%0b d_ack=%0b, expected both seen", name, got_i, got_d);
            i_req = 1'b0;
            d_req = 1'b0;
        end
    endtask

    task automatic wait_beats(input int n, input int b0, input string name);
        for (int c = 0; c < 50; c++) begin
            if (beats_seen - b0 >= n) break;
            @(posedge clk); #1;
        end
        if (beats_seen - b0 < n) begin
            compared++;
            mismatched++;
            $display("FAIL %s_timeout: got %0d beats, expected %0d", name, beats_seen - b0, n);
        end
    endtask

    task automatic do_reset();
        Res = 1'b1; i_req = 1'b0; d_req = 1'b0; mem_rdy = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        Res = 1'b0;
        exp_q.delete();
    endtask

    vec_t vecs[6];

    initial begin
        int m0, d0, a0, b0;
        vecs[0] = '{0, 0, 22'h000013, 32'h0,          0, 32'h0,          4};
        vecs[1] = '{1, 0, 22'h3FFFFF, 32'hCAFE_0001,  1, 32'hDEAD_BEEF,  1};
        vecs[2] = '{1, 1, 22'h000100, 32'h1234_5678,  0, 32'h0,          1};
        vecs[3] = '{0, 0, 22'h3FFFFE, 32'h0,          0, 32'h0,          4};
        vecs[4] = '{1, 0, 22'h000100, 32'h0000_0042,  0, 32'h0,          1};
        vecs[5] = '{0, 0, 22'h000020, 32'h0,          0, 32'h0,          4};

        Res = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; mem_rdy = 1'b1; rd_force_en = 1'b0; rd_force_val = '0;
        repeat (2) begin @(posedge clk); #1; end
        mon_en = 1'b1;
        @(posedge clk); #1;
        Res = 1'b0;
        @(negedge clk);
        check("rst_mem_req", mem_req, 0);
        check("rst_strobes", {i_valid, i_done, d_ack, mem_we}, 0);
        check("rst_mem_addr", mem_addr, 0);

        foreach (vecs[k]) begin
            @(posedge clk); #1;
            m0 = mreq_cycles; d0 = done_cnt; a0 = ack_cnt;
            rd_force_en = vecs[k].force_rd; rd_force_val = vecs[k].fval;
            if (vecs[k].is_d) begin
                push_d(vecs[k].we, vecs[k].addr, vecs[k].wdata,
                       vecs[k].force_rd ? vecs[k].fval : mem_model(vecs[k].addr));
                d_we = vecs[k].we; d_addr = vecs[k].addr; d_wdata = vecs[k].wdata; d_req = 1'b1;
            end else begin
                push_fill(vecs[k].addr);
                i_addr = vecs[k].addr; i_req = 1'b1;
            end
            @(posedge clk); #1;
            // Scramble requester inputs once service has begun; captured values must win.
            i_addr = ~i_addr; d_addr = ~d_addr; d_wdata = ~d_wdata; d_we = ~d_we;
            wait_done(d0, a0, !vecs[k].is_d, vecs[k].is_d, "vec");
            check("vec_mreq_cycles", mreq_cycles - m0, vecs[k].exp_mreq);
            check("vec_queue_empty", exp_q.size(), 0);
            $display("vec %0d: %s addr=0x%06h mreq_cycles=%0d", k, vecs[k].is_d ? "D" : "I",
                     vecs[k].addr, mreq_cycles - m0);
            rd_force_en = 1'b0;
            d_we = 1'b0;
        end

        // Two ties after reset: data wins first, icache wins second.
        do_reset();
        d0 = done_cnt; a0 = ack_cnt;
        push_d(1'b0, 22'h000200, 32'h0, mem_model(22'h000200));
        push_fill(22'h000040);
        d_we = 1'b0; d_addr = 22'h000200; d_wdata = '0; i_addr = 22'h000040;
        i_req = 1'b1; d_req = 1'b1;
        wait_done(d0, a0, 1'b1, 1'b1, "tie1");
        check("tie1_queue_empty", exp_q.size(), 0);
        @(posedge clk); #1;
        d0 = done_cnt; a0 = ack_cnt;
        push_fill(22'h000080);
        push_d(1'b1, 22'h000300, 32'hA5A5_A5A5, 32'h0);
        d_we = 1'b1; d_addr = 22'h000300; d_wdata = 32'hA5A5_A5A5; i_addr = 22'h000080;
        i_req = 1'b1; d_req = 1'b1;
        wait_done(d0, a0, 1'b1, 1'b1, "tie2");
        check("tie2_queue_empty", exp_q.size(), 0);
        d_we = 1'b0;

        // Three-cycle stall on beat 2 of a refill.
        @(posedge clk); #1;
        m0 = mreq_cycles; d0 = done_cnt; a0 = ack_cnt; b0 = beats_seen;
        push_fill(22'h000044);
        i_addr = 22'h000044; i_req = 1'b1;
        wait_beats(2, b0, "stall");
        mem_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1 mem_rdy = 1'b1;
        wait_done(d0, a0, 1'b1, 1'b0, "stall");
        check("stall_mreq_cycles", mreq_cycles - m0, 7);
        $display("stall: mreq_cycles=%0d", mreq_cycles - m0);

        // Reset after beat 1 aborts the burst with no i_done.
        @(posedge clk); #1;
        d0 = done_cnt; b0 = beats_seen;
        push_fill(22'h000088);
        i_addr = 22'h000088; i_req = 1'b1;
        wait_beats(2, b0, "abort");
        Res = 1'b1; mem_rdy = 1'b0; i_req = 1'b0;
        @(posedge clk); #1;
        Res = 1'b0; mem_rdy = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("abort_mem_req", mem_req, 0);
        check("abort_no_done", done_cnt - d0, 0);
        @(posedge clk); #1;
        m0 = mreq_cycles; d0 = done_cnt; a0 = ack_cnt;
        push_fill(22'h000088);
        i_addr = 22'h000088; i_req = 1'b1;
        wait_done(d0, a0, 1'b1, 1'b0, "restart");
        check("restart_mreq_cycles", mreq_cycles - m0, 4);
        check("restart_queue_empty", exp_q.size(), 0);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
